// File: rtl/life_pkg.sv
// Shared constants and types for the board loader.
// Board geometry, preset codes and the loader FSM states.
package life_pkg;

   localparam int BOARD_W = 8;
   localparam int BOARD_H = 8;
   localparam int CELL_AW = 6;

   localparam logic [1:0] PRESET_CLEAR   = 2'd0;
   localparam logic [1:0] PRESET_GLIDER  = 2'd1;
   localparam logic [1:0] PRESET_UW      = 2'd2;
   localparam logic [1:0] PRESET_BLINKER = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_HOST,
      ST_ARM,
      ST_COMMIT
   } state_e;

endpackage

// File: rtl/board_preset_rom.sv
// Preset pattern ROM: one 8-bit board row per (code, row).
// Bit c of row_bits is column c of that row.
module board_preset_rom
   import life_pkg::*;
(
   input  logic [1:0]         preset_sel,
   input  logic [2:0]         row,
   output logic [BOARD_W-1:0] row_bits
);

   always_comb begin
      row_bits = '0;
      case (preset_sel)
         PRESET_CLEAR: row_bits = '0;
         PRESET_GLIDER: begin
            case (row)
               3'd0:    row_bits = 8'h02;
               3'd1:    row_bits = 8'h04;
               3'd2:    row_bits = 8'h07;
               default: row_bits = 8'h00;
            endcase
         end
         PRESET_UW: begin
            case (row)
               3'd0:    row_bits = 8'h09;
               3'd1:    row_bits = 8'h09;
               3'd2:    row_bits = 8'h09;
               3'd3:    row_bits = 8'h06;
               3'd4:    row_bits = 8'h88;
               3'd5:    row_bits = 8'h88;
               3'd6:    row_bits = 8'hA8;
               default: row_bits = 8'h50;
            endcase
         end
         PRESET_BLINKER: begin
            case (row)
               3'd3:    row_bits = 8'h38;
               default: row_bits = 8'h00;
            endcase
         end
         default: row_bits = '0;
      endcase
   end

endmodule

// File: rtl/board_loader.sv
// Stages a board from a preset or host rows, then writes it
// cell by cell into board storage during vertical blanking.
module board_loader #(
   parameter int BOARD_W = 8,
   parameter int BOARD_H = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   preset_sel,
   input  logic         preset_go,
   input  logic         host_valid,
   input  logic [BOARD_W-1:0] host_data,
   output logic         host_ready,
   input  logic         frame_start,
   output logic         wr_en,
   output logic [5:0]   wr_addr,
   output logic         wr_data,
   output logic         busy,
   output logic         load_done
);

   import life_pkg::*;

   localparam int CELLS = BOARD_W * BOARD_H;

   state_e             state_q, state_d;
   logic [2:0]         row_q, row_d;
   logic [1:0]         sel_q, sel_d;
   logic [CELLS-1:0]   stage_q, stage_d;
   logic [CELL_AW-1:0] addr_q, addr_d;
   logic               done_q, done_d;
   logic [7:0]         rom_row;
   logic [5:0]         row_base;

   board_preset_rom u_rom (
      .preset_sel (sel_q),
      .row        (row_q),
      .row_bits   (rom_row)
   );

   assign row_base = {row_q, 3'b000};

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      sel_d   = sel_q;
      stage_d = stage_q;
      addr_d  = addr_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // a preset request beats a host byte arriving together
            if (preset_go) begin
               state_d = ST_FILL;
               row_d   = 3'd0;
               sel_d   = preset_sel;
            end else if (host_valid) begin
               stage_d[7:0] = host_data;
               row_d        = 3'd1;
               state_d      = ST_HOST;
            end
         end
         ST_FILL: begin
            stage_d[row_base +: 8] = rom_row;
            row_d = row_q + 3'd1;
            if (row_q == 3'd7) state_d = ST_ARM;
         end
         ST_HOST: begin
            if (host_valid) begin
               stage_d[row_base +: 8] = host_data;
               row_d = row_q + 3'd1;
               if (row_q == 3'd7) state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            if (frame_start) begin
               state_d = ST_COMMIT;
               addr_d  = '0;
            end
         end
         ST_COMMIT: begin
            addr_d = addr_q + 6'd1;
            if (addr_q == 6'd63) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         sel_q   <= '0;
         stage_q <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         sel_q   <= sel_d;
         stage_q <= stage_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
      end
   end

   // outputs are forced quiet for as long as reset is held
   assign wr_en      = reset && (state_q == ST_COMMIT);
   assign wr_addr    = wr_en ? addr_q : 6'd0;
   assign wr_data    = wr_en && stage_q[addr_q];
   assign busy       = reset && (state_q != ST_IDLE);
   assign host_ready = reset &&
                       ((state_q == ST_IDLE) ||
                        (state_q == ST_HOST));
   assign load_done  = reset && done_q;

endmodule

// File: tb/tb_board_loader.sv
// Directed bench for board_loader: presets, host rows,
// frame_start gating and reset during commit.
module tb_board_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] preset_sel;
   logic       preset_go;
   logic       host_valid;
   logic [7:0] host_data;
   logic       host_ready;
   logic       frame_start;
   logic       wr_en;
   logic [5:0] wr_addr;
   logic       wr_data;
   logic       busy;
   logic       load_done;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [63:0] EXP_GLIDER  = 64'h0000_0000_0007_0402;
   localparam logic [63:0] EXP_HOST    = 64'h0000_0000_0609_0909;
   localparam logic [63:0] EXP_BLINKER = 64'h0000_0000_3800_0000;
   localparam logic [63:0] EXP_UW      = 64'h50A8_8888_0609_0909;

   logic [7:0] host_rows [8] = '{8'h09, 8'h09, 8'h09, 8'h06,
                                 8'h00, 8'h00, 8'h00, 8'h00};

   board_loader dut (
      .clk         (clk),
      .reset       (reset),
      .preset_sel  (preset_sel),
      .preset_go   (preset_go),
      .host_valid  (host_valid),
      .host_data   (host_data),
      .host_ready  (host_ready),
      .frame_start (frame_start),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .load_done   (load_done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_commit(input logic [63:0] exp,
                             input bit poke,
                             input string name);
      repeat (3) tick();
      vectors++;
      if ({wr_en, busy} !== 2'b01) begin
         miscompares++;
         $display("FAIL %s arm_wait: wr_en,busy=%b want 01",
                  name, {wr_en, busy});
      end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int i = 0; i < 64; i++) begin
         logic [5:0] a;
         a = i[5:0];
         vectors++;
         if ({wr_en, wr_addr, wr_data} !== {1'b1, a, exp[i]}) begin
            miscompares++;
            $display("FAIL %s write%0d: en/addr/data=%b/%0d/%b want 1/%0d/%b",
                     name, i, wr_en, wr_addr, wr_data, a, exp[i]);
         end
         if (poke && i == 20) frame_start = 1'b1;
         if (poke && i == 21) frame_start = 1'b0;
         tick();
      end
      vectors++;
      if ({load_done, busy, wr_en} !== 3'b100) begin
         miscompares++;
         $display("FAIL %s done: done,busy,wr_en=%b want 100",
                  name, {load_done, busy, wr_en});
      end
      tick();
      vectors++;
      if (load_done !== 1'b0) begin
         miscompares++;
         $display("FAIL %s done_pulse: load_done=%b want 0",
                  name, load_done);
      end
   endtask

   task automatic load_preset(input logic [1:0] sel,
                              input bit noise,
                              input string name);
      preset_sel = sel;
      preset_go  = 1'b1;
      tick();
      preset_go = 1'b0;
      vectors++;
      if ({busy, host_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL %s fill_entry: busy,ready=%b want 10",
                  name, {busy, host_ready});
      end
      for (int k = 0; k < 8; k++) begin
         frame_start = noise && (k == 3 || k == 7);
         preset_go   = noise && (k == 2);
         preset_sel  = (noise && k == 2) ? ~sel : sel;
         tick();
      end
      frame_start = 1'b0;
      preset_go   = 1'b0;
      preset_sel  = sel;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      preset_sel = 2'd0;
      preset_go = 1'b0;
      host_valid = 1'b0;
      host_data = 8'h00;
      frame_start = 1'b0;
      repeat (2) tick();
      vectors++;
      if ({wr_en, wr_addr, wr_data} !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_wr: en/addr/data=%b/%0d/%b want 0/0/0",
                  wr_en, wr_addr, wr_data);
      end
      vectors++;
      if ({busy, load_done, host_ready} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_status: busy,done,ready=%b want 000",
                  {busy, load_done, host_ready});
      end
      reset = 1'b1;
      tick();
      vectors++;
      if ({busy, host_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL idle_after_reset: busy,ready=%b want 01",
                  {busy, host_ready});
      end
   endtask

   task automatic test_glider;
      load_preset(2'd1, 1'b1, "glider");
      run_commit(EXP_GLIDER, 1'b1, "glider");
   endtask

   task automatic test_host;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      vectors++;
      if ({busy, wr_en} !== 2'b00) begin
         miscompares++;
         $display("FAIL idle_frame_start: busy,wr_en=%b want 00",
                  {busy, wr_en});
      end
      for (int k = 0; k < 8; k++) begin
         int gap;
         gap = $urandom_range(0, 3);
         host_valid = 1'b0;
         host_data  = 8'hA5;
         repeat (gap) tick();
         host_valid = 1'b1;
         host_data  = host_rows[k];
         vectors++;
         if (host_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL host_ready_row%0d: got %b want 1",
                     k, host_ready);
         end
         tick();
      end
      host_valid = 1'b0;
      vectors++;
      if ({host_ready, busy} !== 2'b01) begin
         miscompares++;
         $display("FAIL host_after_8: ready,busy=%b want 01",
                  {host_ready, busy});
      end
      run_commit(EXP_HOST, 1'b0, "host");
   endtask

   task automatic test_go_priority;
      preset_sel = 2'd3;
      preset_go  = 1'b1;
      host_valid = 1'b1;
      host_data  = 8'hFF;
      tick();
      preset_go  = 1'b0;
      host_valid = 1'b0;
      vectors++;
      if ({busy, host_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL go_priority: busy,ready=%b want 10",
                  {busy, host_ready});
      end
      repeat (8) tick();
      run_commit(EXP_BLINKER, 1'b0, "blinker");
   endtask

   task automatic test_uw;
      load_preset(2'd2, 1'b0, "uw");
      run_commit(EXP_UW, 1'b0, "uw");
   endtask

   task automatic test_reset_mid_commit;
      load_preset(2'd1, 1'b0, "midrst");
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (30) tick();
      vectors++;
      if ({wr_en, wr_addr} !== {1'b1, 6'd30}) begin
         miscompares++;
         $display("FAIL midrst_addr: en/addr=%b/%0d want 1/30",
                  wr_en, wr_addr);
      end
      reset = 1'b0;
      tick();
      vectors++;
      if ({wr_en, load_done, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL midrst_stop: en,done,busy=%b want 000",
                  {wr_en, load_done, busy});
      end
      reset = 1'b1;
      repeat (2) tick();
      vectors++;
      if ({wr_en, load_done, busy, host_ready} !== 4'b0001) begin
         miscompares++;
         $display("FAIL midrst_idle: en,done,busy,ready=%b want 0001",
                  {wr_en, load_done, busy, host_ready});
      end
   endtask

   task automatic test_clear;
      load_preset(2'd0, 1'b0, "clear");
      run_commit(64'h0, 1'b0, "clear");
   endtask

   initial begin
      test_reset();
      test_glider();
      test_host();
      test_go_priority();
      test_uw();
      test_reset_mid_commit();
      test_clear();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
